// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction encoder with valid/ready handshakes.
//   S1 captures a request, range-checks the immediate and encodes the word.
//   S2 holds the word presented on the output port.
// Rejected requests (illegal op or immediate) are dropped from S1, never
// reach S2, never consume an address, and raise a one-cycle err_o pulse.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   valid_i    request present
//   ready_o    request accepted when valid_i & ready_o
//   op_i       0 addi, 1 srai, 2 lw, 3 sw, 4 beq, 5-7 illegal
//   rd_i       destination register
//   rs1_i      source register 1
//   rs2_i      source register 2
//   imm_i      signed immediate or shift amount
//   valid_o    instruction word present
//   ready_i    consumer accepts when valid_o & ready_i
//   instr_o    encoded RV32I word
//   addr_o     byte address of instr_o
//   err_o      one-cycle pulse per rejected request
//   err_cnt_o  rejected-request count, saturating at 255
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    localparam logic [2:0] OpAddi = 3'd0;
    localparam logic [2:0] OpSrai = 3'd1;
    localparam logic [2:0] OpLw   = 3'd2;
    localparam logic [2:0] OpSw   = 3'd3;
    localparam logic [2:0] OpBeq  = 3'd4;

    // S1 stage
    logic        s1_valid_q;
    logic        s1_legal_q;
    logic [31:0] s1_instr_q;
    // S2 stage
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    // Address the next legal word will carry
    logic [31:0] next_addr_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    logic        imm12_ok;
    logic        imm13_ok;
    logic        enc_legal;
    logic [31:0] enc_word;
    logic        s2_free;
    logic        s2_load;
    logic        s1_adv;
    logic        s1_drop;

    // Immediate fits a signed 12/13-bit field when the upper bits are pure sign extension.
    assign imm12_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign imm13_ok = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        case (op_i)
            OpAddi: begin
                enc_word  = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b0010011};
                enc_legal = imm12_ok;
            end
            OpSrai: begin
                enc_word  = {7'b0100000, imm_i[4:0], rs1_i, 3'b101, rd_i, 7'b0010011};
                enc_legal = ~(|imm_i[31:5]);
            end
            OpLw: begin
                enc_word  = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
                enc_legal = imm12_ok;
            end
            OpSw: begin
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
                enc_legal = imm12_ok;
            end
            OpBeq: begin
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                             imm_i[4:1], imm_i[11], 7'b1100011};
                enc_legal = imm13_ok;
            end
            default: begin
                enc_word  = 32'h0;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign s2_free = ~valid_q | ready_i;
    assign s2_load = s1_valid_q & s1_legal_q & s2_free;
    // A rejected entry needs no room in S2, so it always leaves S1 on the next edge.
    assign s1_drop = s1_valid_q & ~s1_legal_q;
    assign s1_adv  = ~s1_valid_q | s1_drop | s2_load;
    assign ready_o = s1_adv;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_legal_q  <= 1'b0;
            s1_instr_q  <= 32'h0;
            valid_q     <= 1'b0;
            instr_q     <= 32'h0;
            addr_q      <= BASE_ADDR;
            next_addr_q <= BASE_ADDR;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'h0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= valid_i;
                if (valid_i) begin
                    s1_legal_q <= enc_legal;
                    s1_instr_q <= enc_word;
                end
            end

            if (s2_load) begin
                valid_q     <= 1'b1;
                instr_q     <= s1_instr_q;
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + ADDR_STEP;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end

            err_q <= s1_drop;
            if (s1_drop && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign addr_o    = addr_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  BASE_ADDR  32'h0000_0000  address_o value after reset
  ADDR_STEP  4              address_o increment per emitted instruction
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_i  in  1  single clock; all state changes on rising edge
  rst_i  in  1  reset, asynchronous, active-high
  valid_i  in  1  request present
  ready_o  out  1  request accepted when valid_i & ready_o
  op_i  in  3  0 addi, 1 srai, 2 lw, 3 sw, 4 beq, 5-7 illegal
  rd_i  in  5  destination register
  rs1_i  in  5  source register 1
  rs2_i  in  5  source register 2
  imm_i  in  32  signed immediate or shift amount
  valid_o  out  1  instruction word present
  ready_i  in  1  consumer accepts when valid_o & ready_i
  instr_o  out  32  encoded RV32I word
  addr_o  out  32  instruction-memory byte address for instr_o
  err_o  out  1  one-cycle pulse: a request was rejected
  err_cnt_o  out  8  rejected-request count, saturates at 255

Function
REQ-003 Datapath SHALL be two registered stages: S1 (capture, range check, encode) and S2 (output); the S2 register drives valid_o, instr_o and addr_o.
REQ-004 Latency SHALL be 2 cycles from acceptance to valid_o with ready_i held high; throughput SHALL be 1 instruction per cycle.
REQ-005 S2 SHALL load when S2 is empty or (valid_o & ready_i); S1 SHALL advance when S2 loads or S1 is empty; ready_o SHALL equal (S1 empty) | (S1 advancing); ready_o SHALL NOT depend on valid_i.
REQ-006 While valid_o=1 & ready_i=0, instr_o, addr_o and valid_o SHALL stay stable.
REQ-007 Encoding SHALL be: addi = {imm[11:0],rs1,000,rd,0010011}; srai = {0100000,imm[4:0],rs1,101,rd,0010011}; lw = {imm[11:0],rs1,010,rd,0000011}; sw = {imm[11:5],rs2,rs1,010,imm[4:0],0100011}; beq = {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}.
REQ-008 Legal immediates SHALL be: addi/lw/sw -2048..2047; srai 0..31; beq -4096..4094 with imm[0]=0.
REQ-009 An illegal op or out-of-range immediate SHALL be accepted in S1, SHALL NOT reach S2, SHALL NOT advance addr_o, and SHALL pulse err_o for exactly the cycle after S1 advances.
REQ-010 err_cnt_o SHALL increment by 1 per rejected request and hold at 255.
REQ-011 addr_o SHALL equal the address of the current S2 word; the next legal word SHALL carry the previous address + ADDR_STEP (mod 2^32, wraps at 0xFFFF_FFFC -> 0x0).
REQ-012 If an output handshake and a new S1 load occur in the same cycle, both SHALL take effect with no bubble and no duplication.
REQ-013 Back-to-back rejected requests SHALL produce one err_o pulse each on consecutive cycles.

Reset
REQ-014 On rst_i=1, asynchronously: valid_o=0, S1 empty, instr_o=0, addr_o=BASE_ADDR, err_o=0, err_cnt_o=0; ready_o SHALL be 1 from the first clock edge after release.
REQ-015 Reset mid-operation SHALL discard S1 and S2 contents; no word in flight SHALL appear after reset.

Verification
REQ-016 addi, rd=1, rs1=0, imm=5, ready_i=1 -> 2 cycles later valid_o=1, instr_o=0x00500093, addr_o=0x0.
REQ-017 sw, rs2=2, rs1=3, imm=-4, then beq, rs1=1, rs2=2, imm=-8, back-to-back -> instr_o 0xFE21AE23 at addr 0x0, then 0xFE208CE3 at addr 0x4, on consecutive cycles.
REQ-018 ready_i=0 for 5 cycles with valid_i=1 continuously -> exactly 2 requests accepted, ready_o=0 afterwards, instr_o stable; on ready_i=1 both words drain in order with no loss.
REQ-019 addi imm=2048, beq imm=3, op=6 -> three err_o pulses, err_cnt_o=3, valid_o never set, addr_o unchanged; 300 rejects -> err_cnt_o=255.
REQ-020 rst_i asserted asynchronously between clock edges while S1 and S2 are full -> valid_o=0 and addr_o=BASE_ADDR immediately, without waiting for a clock edge; both entries lost.
REQ-021 BASE_ADDR=0xFFFF_FFF8, three legal requests -> addr_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
